// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: byte width, FSM encoding and
// the modular index helper used by the rotating-priority logic.
package uart_tx_arbiter_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } arb_state_t;

  // (base + off) mod n, for base < n and off < n
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotating-priority select: first asserted request at or after
// rr_ptr_i, wrapping to index 0.
module uart_rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               any_req_o,
  output logic [ID_W-1:0]    sel_id_o
);

  // Scan from farthest to nearest so the closest candidate to rr_ptr wins.
  always_comb begin
    any_req_o = 1'b0;
    sel_id_o  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(int'(rr_ptr_i), k, NUM_REQ)]) begin
        any_req_o = 1'b1;
        sel_id_o  = ID_W'(wrap_idx(int'(rr_ptr_i), k, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters with
// round-robin grants locked per message and a stalled-requester gap timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 1024,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           grant_active,
  output logic [ID_W-1:0]                grant_id,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           timeout_pulse,
  output logic [1:0]                     dbg_state
);

  localparam int GAP_W = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

  arb_state_t             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   grant_active_q, grant_active_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   last_q, last_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

  logic                   any_req;
  logic [ID_W-1:0]        sel_id;
  logic [ID_W-1:0]        next_ptr;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .sel_id_o  (sel_id)
  );

  assign next_ptr = ID_W'(wrap_idx(int'(grant_id_q), 1, NUM_REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
      gap_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      gap_cnt_q      <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    gap_cnt_d      = gap_cnt_q;
    req_ready      = '0;
    tx_start       = 1'b0;
    timeout_pulse  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_id_d     = sel_id;
          grant_active_d = 1'b1;
          gap_cnt_d      = '0;
          state_d        = ST_FETCH;
        end
      end
      ST_FETCH: begin
        req_ready = NUM_REQ'(1) << grant_id_q;
        if (req_valid[grant_id_q]) begin
          tx_data_d = req_data[int'(grant_id_q)*UART_BYTE_W +: UART_BYTE_W];
          last_d    = req_last[grant_id_q];
          gap_cnt_d = '0;
          state_d   = ST_START;
        end else if (gap_cnt_q == GAP_W'(GAP_TIMEOUT - 1)) begin
          // Locked requester went quiet mid-message: give the line back.
          timeout_pulse  = 1'b1;
          grant_active_d = 1'b0;
          rr_ptr_d       = next_ptr;
          gap_cnt_d      = '0;
          state_d        = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            grant_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign tx_data      = tx_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester message queues, a 10-cycle UART
// model, and a round-robin message-order reference model feeding exp_q.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int GAP_TIMEOUT = 16;
  localparam int ID_W        = 2;
  localparam int UART_CYC    = 10;

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*8-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   grant_active;
  logic [ID_W-1:0]        grant_id;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   timeout_pulse;
  logic [1:0]             dbg_state;

  int tests = 0;
  int fails = 0;

  // {last, data} per requester: what the drivers present, and the model copy
  logic [8:0]  msg_q [NUM_REQ][$];
  logic [8:0]  pend  [NUM_REQ][$];
  logic [11:0] exp_q [$];
  int          model_ptr = 0;
  int          exp_to = 0;
  int          seen_to = 0;
  int          start_cnt = 0;

  int  start_dly [NUM_REQ];
  int  gap_dly   [NUM_REQ];
  bit  hs_q      [NUM_REQ];
  int  stall = 0;
  bit  ga_chk = 0;
  int  uart_cnt = 0;
  int  hold_cnt = 0;
  bit  hold_arm = 0;
  bit  hold_track = 0;
  int  hold_wait = 0;
  int  hold_result = -1;
  bit  spurious = 0;
  logic [7:0] cur_byte = '0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_TIMEOUT(GAP_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant_active  (grant_active),
    .grant_id      (grant_id),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .timeout_pulse (timeout_pulse),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- drivers, uart model and monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_q[i]) begin
          void'(msg_q[i].pop_front());
          gap_dly[i] = $urandom_range(0, 2);
          hs_q[i] = 1'b0;
        end
        if (start_dly[i] > 0) start_dly[i]--;
        else if (gap_dly[i] > 0) gap_dly[i]--;
        if (start_dly[i] == 0 && gap_dly[i] == 0 && msg_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = msg_q[i][0][7:0];
          req_last[i] = msg_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
      tx_done = 1'b0;
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) tx_done = 1'b1;
      end
      if (hold_cnt > 0) hold_cnt--;
      if (spurious) begin
        tx_done = 1'b1;
        spurious = 1'b0;
      end
      tx_busy = (uart_cnt > 0) || (hold_cnt > 0);
    end
    #1;
    if (!rst) begin
      tests++;
      if (req_ready !== 4'd0 && req_ready !== (4'd1 << grant_id)) begin
        $display("FAIL ready_onehot: req_ready=%b grant_id=%0d, required 0 or one-hot at grant_id", req_ready, grant_id);
        fails++;
      end
      if (ga_chk) begin
        ga_chk = 0;
        tests++;
        if (grant_active !== 1'b0) begin
          $display("FAIL timeout_release: grant_active=%b after timeout, required 0", grant_active);
          fails++;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) hs_q[i] = req_valid[i] && req_ready[i];
      if (req_ready != 0) begin
        if ((req_valid & req_ready) != 0) stall = 0;
        else stall++;
      end
      if (timeout_pulse) begin
        seen_to++;
        tests++;
        if (stall != GAP_TIMEOUT) begin
          $display("FAIL timeout_gap: pulse after %0d stalled FETCH cycles, required %0d", stall, GAP_TIMEOUT);
          fails++;
        end
        stall = 0;
        ga_chk = 1;
      end
      if (hold_track) begin
        if (tx_start) begin
          hold_track = 0;
          hold_result = hold_wait;
        end else hold_wait++;
      end
      if (tx_start) begin
        logic [11:0] exp_v;
        start_cnt++;
        tests++;
        if (tx_busy !== 1'b0) begin
          $display("FAIL start_busy: tx_start with tx_busy=%b, required busy 0", tx_busy);
          fails++;
        end
        tests++;
        if (exp_q.size() == 0) begin
          $display("FAIL tx_byte: unexpected byte id=%0d data=%02h, required no start", grant_id, tx_data);
          fails++;
        end else begin
          exp_v = exp_q.pop_front();
          if ({4'(grant_id), tx_data} !== exp_v) begin
            $display("FAIL tx_byte: got id=%0d data=%02h, required id=%0d data=%02h",
                     grant_id, tx_data, exp_v[11:8], exp_v[7:0]);
            fails++;
          end
        end
        cur_byte = tx_data;
        uart_cnt = UART_CYC;
      end
      if (hold_arm && (req_valid & req_ready) != 0) begin
        hold_arm = 0;
        hold_cnt = 6;
        tx_busy = 1'b1;
        hold_wait = 0;
        hold_track = 1;
      end
      if (tx_done && grant_active) begin
        tests++;
        if (tx_data !== cur_byte) begin
          $display("FAIL tx_data_stable: tx_data=%02h at tx_done, required %02h", tx_data, cur_byte);
          fails++;
        end
      end
    end
  end

  // ---------------- stimulus and reference model ----------------
  task automatic push_byte(input int id, input logic [7:0] b, input bit last);
    msg_q[id].push_back({last, b});
    pend[id].push_back({last, b});
  endtask

  task automatic load_msg(input int id, input int len, input bit term_last, input int dly);
    for (int k = 0; k < len; k++) push_byte(id, 8'($urandom), term_last && (k == len - 1));
    start_dly[id] = dly;
  endtask

  // Whole messages are served one at a time, winner = first pending
  // requester at or after the pointer, pointer moves past the winner.
  task automatic expect_order();
    int id;
    logic [8:0] e;
    forever begin
      id = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (id < 0 && pend[(model_ptr + k) % NUM_REQ].size() > 0) id = (model_ptr + k) % NUM_REQ;
      if (id < 0) break;
      e = '0;
      while (pend[id].size() > 0) begin
        e = pend[id].pop_front();
        exp_q.push_back({4'(id), e[7:0]});
      end
      if (!e[8]) exp_to++;
      model_ptr = (id + 1) % NUM_REQ;
    end
  endtask

  function automatic bit quiet();
    bit q;
    q = (exp_q.size() == 0) && (uart_cnt == 0) && (hold_cnt == 0) && (grant_active === 1'b0);
    for (int i = 0; i < NUM_REQ; i++) if (msg_q[i].size() != 0) q = 0;
    return q;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #2;
      if (quiet()) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic clear_tb();
    for (int i = 0; i < NUM_REQ; i++) begin
      msg_q[i].delete();
      pend[i].delete();
      start_dly[i] = 0;
      gap_dly[i] = 0;
      hs_q[i] = 0;
    end
    exp_q.delete();
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    uart_cnt = 0;
    hold_cnt = 0;
    hold_arm = 0;
    hold_track = 0;
    stall = 0;
    ga_chk = 0;
    model_ptr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (req_ready !== 4'd0 || grant_active !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h00 ||
        tx_start !== 1'b0 || timeout_pulse !== 1'b0 || dbg_state !== ST_IDLE) begin
      $display("FAIL %s: ready=%b ga=%b gid=%0d data=%02h start=%b to=%b st=%0d, required all zero / IDLE",
               tag, req_ready, grant_active, grant_id, tx_data, tx_start, timeout_pulse, dbg_state);
      fails++;
    end
  endtask

  task automatic test_reset();
    clear_tb();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int s0;
    s0 = start_cnt;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b1);
    expect_order();
    wait_idle(2000, ok);
    tests++;
    if (!ok || start_cnt - s0 != 2) begin
      $display("FAIL single_msg: idle=%0d starts=%0d, required idle=1 starts=2", ok, start_cnt - s0);
      fails++;
    end
  endtask

  task automatic test_contention();
    bit ok;
    load_msg(1, $urandom_range(1, 3), 1, 0);
    load_msg(3, $urandom_range(1, 3), 1, 0);
    expect_order();
    wait_idle(2000, ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      $display("FAIL contention_1_3: idle=%0d left=%0d, required idle=1 left=0", ok, exp_q.size());
      fails++;
    end
    load_msg(0, $urandom_range(1, 3), 1, 0);
    load_msg(3, $urandom_range(1, 3), 1, 0);
    expect_order();
    wait_idle(2000, ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      $display("FAIL contention_0_3: idle=%0d left=%0d, required idle=1 left=0", ok, exp_q.size());
      fails++;
    end
  endtask

  task automatic test_random();
    bit ok;
    int mask;
    for (int r = 0; r < 8; r++) begin
      mask = $urandom_range(1, 15);
      for (int i = 0; i < NUM_REQ; i++)
        if (mask[i]) load_msg(i, $urandom_range(1, 4), 1, 0);
      expect_order();
      wait_idle(4000, ok);
      tests++;
      if (!ok || exp_q.size() != 0) begin
        $display("FAIL random_round%0d: idle=%0d left=%0d, required idle=1 left=0", r, ok, exp_q.size());
        fails++;
      end
    end
  endtask

  task automatic test_locked();
    bit ok;
    int bad0;
    load_msg(2, 3, 1, 0);
    expect_order();
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (grant_active === 1'b1 && grant_id === 2'd2) begin
        ok = 1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      $display("FAIL lock_req2: grant never went to 2, grant_id=%0d", grant_id);
      fails++;
    end
    load_msg(0, 2, 1, 0);
    expect_order();
    bad0 = 0;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #2;
      if (grant_active && grant_id == 2'd2 && req_ready[0]) bad0++;
      if (quiet()) begin
        ok = 1;
        break;
      end
    end
    tests++;
    if (!ok || bad0 != 0) begin
      $display("FAIL locked_no_interleave: idle=%0d ready0_cycles=%0d, required idle=1 and 0", ok, bad0);
      fails++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    load_msg(1, 1, 0, 0);
    load_msg(2, 2, 1, 0);
    expect_order();
    wait_idle(2000, ok);
    tests++;
    if (!ok || seen_to != exp_to || exp_q.size() != 0) begin
      $display("FAIL timeout_then_next: idle=%0d timeouts=%0d, required idle=1 timeouts=%0d", ok, seen_to, exp_to);
      fails++;
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int s0;
    hold_result = -1;
    hold_arm = 1;
    load_msg(3, 1, 1, 0);
    expect_order();
    wait_idle(2000, ok);
    tests++;
    if (!ok || hold_result != 5) begin
      $display("FAIL busy_hold: idle=%0d start after %0d busy cycles, required 5", ok, hold_result);
      fails++;
    end
    s0 = start_cnt;
    spurious = 1;
    repeat (4) @(negedge clk);
    #2;
    tests++;
    if (grant_active !== 1'b0 || start_cnt != s0 || dbg_state !== ST_IDLE) begin
      $display("FAIL spurious_done: ga=%b new_starts=%0d st=%0d, required 0, 0, IDLE", grant_active, start_cnt - s0, dbg_state);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0;
    s0 = start_cnt;
    load_msg(2, 3, 1, 0);
    expect_order();
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #2;
      if (start_cnt - s0 >= 2) begin
        ok = 1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      $display("FAIL reset_mid_setup: second byte start not seen, starts=%0d", start_cnt - s0);
      fails++;
    end
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    clear_tb();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_msg(1, 2, 1, 0);
    load_msg(3, 2, 1, 0);
    expect_order();
    wait_idle(2000, ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      $display("FAIL reset_rearb: idle=%0d left=%0d, required idle=1 left=0", ok, exp_q.size());
      fails++;
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_tb();
    test_reset();
    test_single();
    test_contention();
    test_locked();
    test_timeout();
    test_busy_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
